// File: rtl/dmac_chan_arbiter.sv
// rtl/dmac_chan_arbiter.sv - DMA channel arbiter: request capture, fixed/round-robin arbitration, bus handshake, completion interrupts
module dmac_chan_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int RR_MODE = 0,
    parameter int SW      = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] DmacReq,
    input  logic [NUM_CH-1:0] Ch_Mask,
    input  logic              Ch_Done,
    input  logic              Bus_Grant,
    input  logic [NUM_CH-1:0] Irq_Clr,
    output logic [NUM_CH-1:0] ReqAck,
    output logic              Bus_Req,
    output logic [NUM_CH-1:0] Ch_En,
    output logic [SW-1:0]     Ch_Sel,
    output logic              Xfer_Go,
    output logic              Busy,
    output logic [NUM_CH-1:0] Ch_Irq,
    output logic              Interrupt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK    = 2'd1,
        BUS    = 2'd2,
        ACTIVE = 2'd3
    } state_t;

    state_t            state;
    state_t            next_state;

    logic [NUM_CH-1:0] prev_req;
    logic              primed;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] req_rise;
    logic [NUM_CH-1:0] sel_onehot;
    logic [NUM_CH-1:0] done_set;
    logic [SW-1:0]     ptr;
    logic [SW-1:0]     ptr_next;
    logic [SW-1:0]     ch_sel_q;
    logic [SW-1:0]     winner;
    logic [SW-1:0]     low_win;
    logic [SW-1:0]     hi_win;
    logic              hi_found;
    logic [NUM_CH-1:0] ch_irq_q;
    logic              done_evt;

    // A masked channel may still hold a stale pending bit for one cycle; never let it win.
    assign eligible = pending & Ch_Mask;

    // primed stays low for the first edge after reset so a level held high through reset is not an edge.
    assign req_rise = DmacReq & ~prev_req & Ch_Mask & {NUM_CH{primed}};

    assign done_evt = (state == ACTIVE) && Ch_Done;
    assign done_set = done_evt ? sel_onehot : '0;

    assign ptr_next = (ch_sel_q == SW'(NUM_CH - 1)) ? '0 : ch_sel_q + SW'(1);

    // Decode the owning channel index into a one-hot vector.
    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sel_onehot[i] = (ch_sel_q == SW'(i));
        end
    end

    // Winner select: lowest eligible index, or first eligible at/above ptr with wrap.
    always_comb begin
        low_win  = '0;
        hi_win   = '0;
        hi_found = 1'b0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                low_win = SW'(i);
            end
            if (eligible[i] && (SW'(i) >= ptr)) begin
                hi_win   = SW'(i);
                hi_found = 1'b1;
            end
        end
        if ((RR_MODE != 0) && hi_found) begin
            winner = hi_win;
        end else begin
            winner = low_win;
        end
    end

    // Request edge tracking and pending set/clear; a new edge beats a same-cycle ack clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_req <= '0;
            primed   <= 1'b0;
            pending  <= '0;
        end else begin
            prev_req <= DmacReq;
            primed   <= 1'b1;
            pending  <= (pending & ~ReqAck & Ch_Mask) | req_rise;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|eligible) next_state = ACK;
            ACK:     next_state = BUS;
            BUS:     if (Bus_Grant) next_state = ACTIVE;
            ACTIVE:  if (Ch_Done) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs; grant loss in ACTIVE only gates Xfer_Go, ownership is kept.
    always_comb begin
        ReqAck  = '0;
        Bus_Req = 1'b0;
        Ch_En   = '0;
        Xfer_Go = 1'b0;
        Busy    = (state != IDLE);
        case (state)
            ACK: begin
                ReqAck = sel_onehot;
            end
            BUS: begin
                Bus_Req = 1'b1;
                Ch_En   = sel_onehot;
            end
            ACTIVE: begin
                Bus_Req = 1'b1;
                Ch_En   = sel_onehot;
                Xfer_Go = Bus_Grant;
            end
            default: begin
            end
        endcase
    end

    // Latch the winner on arbitration and advance the round-robin pointer on completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_sel_q <= '0;
            ptr      <= '0;
        end else begin
            if ((state == IDLE) && (|eligible)) begin
                ch_sel_q <= winner;
            end
            if (done_evt) begin
                ptr <= ptr_next;
            end
        end
    end

    // Sticky completion flags; a completion beats a same-cycle write-1-to-clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ch_irq_q <= '0;
        end else begin
            ch_irq_q <= (ch_irq_q & ~Irq_Clr) | done_set;
        end
    end

    assign Ch_Sel    = ch_sel_q;
    assign Ch_Irq    = ch_irq_q;
    assign Interrupt = |ch_irq_q;

endmodule

// File: tb/tb_dmac_chan_arbiter.sv
// tb/tb_dmac_chan_arbiter.sv - self-checking bench for dmac_chan_arbiter (fixed-priority and round-robin instances)
module tb_dmac_chan_arbiter;

    logic       clk;
    logic       rst;

    logic [3:0] a_req, a_mask, a_clr;
    logic       a_done, a_grant;
    logic [3:0] a_ack, a_en, a_irq;
    logic [1:0] a_sel;
    logic       a_br, a_xgo, a_busy, a_int;

    logic [3:0] b_req, b_mask, b_clr;
    logic       b_done, b_grant;
    logic [3:0] b_ack, b_en, b_irq;
    logic [1:0] b_sel;
    logic       b_br, b_xgo, b_busy, b_int;

    logic [17:0] a_obs, b_obs;
    assign a_obs = {a_ack, a_br, a_en, a_sel, a_xgo, a_busy, a_irq, a_int};
    assign b_obs = {b_ack, b_br, b_en, b_sel, b_xgo, b_busy, b_irq, b_int};

    int n_cmp  = 0;
    int n_fail = 0;

    dmac_chan_arbiter #(.NUM_CH(4), .RR_MODE(0)) u_fp (
        .clk(clk), .rst(rst), .DmacReq(a_req), .Ch_Mask(a_mask), .Ch_Done(a_done),
        .Bus_Grant(a_grant), .Irq_Clr(a_clr), .ReqAck(a_ack), .Bus_Req(a_br),
        .Ch_En(a_en), .Ch_Sel(a_sel), .Xfer_Go(a_xgo), .Busy(a_busy),
        .Ch_Irq(a_irq), .Interrupt(a_int)
    );

    dmac_chan_arbiter #(.NUM_CH(4), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .DmacReq(b_req), .Ch_Mask(b_mask), .Ch_Done(b_done),
        .Bus_Grant(b_grant), .Irq_Clr(b_clr), .ReqAck(b_ack), .Bus_Req(b_br),
        .Ch_En(b_en), .Ch_Sel(b_sel), .Xfer_Go(b_xgo), .Busy(b_busy),
        .Ch_Irq(b_irq), .Interrupt(b_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] req;
        logic [3:0] mask;
        logic       done;
        logic       grant;
        logic [3:0] clr;
        logic [17:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] exp_o(input logic [3:0] ack, input logic br, input logic [3:0] en,
                                          input logic [1:0] sel, input logic xgo, input logic busy,
                                          input logic [3:0] irq, input logic intr);
        return {ack, br, en, sel, xgo, busy, irq, intr};
    endfunction

    function automatic void add(input string nm, input logic [3:0] req, input logic [3:0] mask,
                                input logic done, input logic grant, input logic [3:0] clr,
                                input logic [17:0] exp);
        vec_t v;
        v.name = nm; v.req = req; v.mask = mask; v.done = done;
        v.grant = grant; v.clr = clr; v.exp = exp;
        vecs.push_back(v);
    endfunction

    // One complete round-robin service: wait for ack, grant the bus, complete with Ch_Done.
    task automatic rr_service(input int exp_ch, input logic [3:0] inject, input string nm);
        int n;
        logic [3:0] exp_hot;
        exp_hot = 4'b0001 << exp_ch;
        n = 0;
        @(negedge clk);
        while (b_ack == 4'b0000 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_ack"}, 32'(b_ack), 32'(exp_hot));
        b_req   = b_req | inject;
        b_grant = 1'b1;
        n = 0;
        @(negedge clk);
        while (!b_xgo && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_xgo"}, 32'(b_xgo), 32'(1'b1));
        check({nm, "_sel"}, 32'(b_sel), 32'(exp_ch));
        check({nm, "_en"}, 32'(b_en), 32'(exp_hot));
        b_done = 1'b1;
        @(negedge clk);
        b_done  = 1'b0;
        b_grant = 1'b0;
    endtask

    initial begin
        int  n;
        logic ack_seen;

        // Fixed-priority cycle table: inputs for the cycle and outputs observed before its closing edge.
        add("idle",        4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, exp_o(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0));
        add("rise_0110",   4'b0110, 4'b1111, 1'b0, 1'b0, 4'b0000, exp_o(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0));
        add("arb_idle",    4'b0110, 4'b1111, 1'b0, 1'b0, 4'b0000, exp_o(4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000, 1'b0));
        add("ack_ch1",     4'b0110, 4'b1111, 1'b0, 1'b0, 4'b0000, exp_o(4'b0010, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b1, 4'b0000, 1'b0));
        add("bus_wait",    4'b0110, 4'b1111, 1'b0, 1'b0, 4'b0000, exp_o(4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1, 4'b0000, 1'b0));
        add("bus_grant",   4'b0110, 4'b1111, 1'b0, 1'b1, 4'b0000, exp_o(4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1, 4'b0000, 1'b0));
        add("active_go",   4'b0110, 4'b1111, 1'b0, 1'b1, 4'b0000, exp_o(4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 4'b0000, 1'b0));
        add("grant_lost",  4'b0110, 4'b1111, 1'b0, 1'b0, 4'b0000, exp_o(4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1, 4'b0000, 1'b0));
        add("grant_back",  4'b0110, 4'b1111, 1'b0, 1'b1, 4'b0000, exp_o(4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 4'b0000, 1'b0));
        add("done_ch1",    4'b0110, 4'b1111, 1'b1, 1'b1, 4'b0010, exp_o(4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 4'b0000, 1'b0));
        add("irq1_set",    4'b0110, 4'b1111, 1'b0, 1'b1, 4'b0010, exp_o(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 4'b0010, 1'b1));
        add("ack_ch2",     4'b0110, 4'b1111, 1'b1, 1'b1, 4'b0000, exp_o(4'b0100, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b1, 4'b0000, 1'b0));
        add("bus_done_ign",4'b0110, 4'b1111, 1'b1, 1'b1, 4'b0000, exp_o(4'b0000, 1'b1, 4'b0100, 2'd2, 1'b0, 1'b1, 4'b0000, 1'b0));
        add("active_ch2",  4'b0110, 4'b1111, 1'b0, 1'b1, 4'b0000, exp_o(4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 4'b0000, 1'b0));
        add("done_ch2",    4'b0110, 4'b1111, 1'b1, 1'b1, 4'b0000, exp_o(4'b0000, 1'b1, 4'b0100, 2'd2, 1'b1, 1'b1, 4'b0000, 1'b0));
        add("irq2_set",    4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0100, exp_o(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 4'b0100, 1'b1));
        add("irq2_clr",    4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, exp_o(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 4'b0000, 1'b0));
        add("rise_again",  4'b0110, 4'b1111, 1'b0, 1'b0, 4'b0000, exp_o(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 4'b0000, 1'b0));
        add("mask_ch2",    4'b0110, 4'b1011, 1'b0, 1'b0, 4'b0000, exp_o(4'b0000, 1'b0, 4'b0000, 2'd2, 1'b0, 1'b0, 4'b0000, 1'b0));
        add("ack_ch1_b",   4'b0110, 4'b1011, 1'b0, 1'b0, 4'b0000, exp_o(4'b0010, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b1, 4'b0000, 1'b0));
        add("bus_ch1_b",   4'b0110, 4'b1011, 1'b0, 1'b1, 4'b0000, exp_o(4'b0000, 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1, 4'b0000, 1'b0));
        add("mask_owner",  4'b0110, 4'b1001, 1'b0, 1'b1, 4'b0000, exp_o(4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 4'b0000, 1'b0));
        add("done_masked", 4'b0110, 4'b1001, 1'b1, 1'b1, 4'b0000, exp_o(4'b0000, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1, 4'b0000, 1'b0));
        add("no_ch2",      4'b0110, 4'b1111, 1'b0, 1'b0, 4'b0010, exp_o(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 4'b0010, 1'b1));
        add("idle_end",    4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, exp_o(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b0));
        add("idle_end2",   4'b0000, 4'b1111, 1'b0, 1'b0, 4'b0000, exp_o(4'b0000, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b0, 4'b0000, 1'b0));

        rst = 1'b0;
        a_req = 4'b0000; a_mask = 4'b1111; a_done = 1'b0; a_grant = 1'b0; a_clr = 4'b0000;
        b_req = 4'b0000; b_mask = 4'b1111; b_done = 1'b0; b_grant = 1'b0; b_clr = 4'b0000;

        #2;
        check("reset_fp", 32'(a_obs), 32'(18'd0));
        check("reset_rr", 32'(b_obs), 32'(18'd0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            a_req   = vecs[i].req;
            a_mask  = vecs[i].mask;
            a_done  = vecs[i].done;
            a_grant = vecs[i].grant;
            a_clr   = vecs[i].clr;
            @(negedge clk);
            check(vecs[i].name, 32'(a_obs), 32'(vecs[i].exp));
            @(posedge clk);
            #1;
        end
        a_req = 4'b0000; a_done = 1'b0; a_grant = 1'b0; a_clr = 4'b0000; a_mask = 4'b1111;

        // Round-robin: simultaneous rise serves 0..3, ch0 re-raised during ch3 wins after ptr wraps.
        @(negedge clk);
        b_req = 4'b1111;
        rr_service(0, 4'b0000, "rr0");
        b_req = 4'b0000;
        rr_service(1, 4'b0000, "rr1");
        rr_service(2, 4'b0000, "rr2");
        rr_service(3, 4'b0001, "rr3");
        rr_service(0, 4'b0000, "rr_wrap0");
        check("rr_irq_all", 32'(b_irq), 32'(4'b1111));
        check("rr_interrupt", 32'(b_int), 32'(1'b1));
        // ptr is now 1: with ch0 and ch3 rising together, ch3 must win over ch0.
        b_req = 4'b0000;
        @(negedge clk);
        b_req = 4'b1001;
        rr_service(3, 4'b0000, "rr_ptr3");
        rr_service(0, 4'b0000, "rr_ptr0");
        b_req = 4'b0000;

        // Asynchronous reset in ACTIVE, then a request level held through reset must not ack.
        @(negedge clk);
        a_req   = 4'b0001;
        a_grant = 1'b1;
        n = 0;
        @(negedge clk);
        while (!a_xgo && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rst_reach_active", 32'(a_xgo), 32'(1'b1));
        #2;
        rst = 1'b0;
        #1;
        check("rst_async_drop", 32'({a_br, a_en, a_busy, a_xgo, a_ack}), 32'(0));
        check("rst_async_sel", 32'(a_sel), 32'(2'd0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        ack_seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (a_ack != 4'b0000) ack_seen = 1'b1;
        end
        check("held_req_no_ack", 32'(ack_seen), 32'(1'b0));
        check("held_req_idle", 32'(a_busy), 32'(1'b0));
        a_req = 4'b0000;
        @(negedge clk);
        a_req = 4'b0001;
        n = 0;
        @(negedge clk);
        while (a_ack == 4'b0000 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("rerise_ack", 32'(a_ack), 32'(4'b0001));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dmac_chan_arbiter.md
DMAC_CHAN_ARBITER -- requirements
Module: dmac_chan_arbiter

Interface
REQ-001: Parameter NUM_CH, default 4, sets the number of DMA channels; the legal range SHALL be 2..16 and need not be a power of two.
REQ-002: Parameter RR_MODE, default 0, selects the arbitration policy: 0 SHALL mean fixed priority and 1 SHALL mean round-robin.
REQ-003: Parameter SW = $clog2(NUM_CH) SHALL set the width of the channel index.
REQ-004: clk, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005: rst, input, 1, SHALL be an asynchronous, active-low reset.
REQ-006: DmacReq, input, NUM_CH, SHALL carry the peripheral request levels, one bit per channel.
REQ-007: Ch_Mask, input, NUM_CH, SHALL be the software channel enable; 1 = channel enabled.
REQ-008: Ch_Done, input, 1, SHALL be the end-of-transfer pulse from the active channel engine.
REQ-009: Bus_Grant, input, 1, SHALL be the AHB arbiter grant.
REQ-010: Irq_Clr, input, NUM_CH, SHALL be the per-channel write-1-to-clear for interrupts.
REQ-011: ReqAck, output, NUM_CH, SHALL be a one-cycle acknowledge pulse to the peripheral.
REQ-012: Bus_Req, output, 1, SHALL be the AHB bus request.
REQ-013: Ch_En, output, NUM_CH, SHALL be the one-hot enable of the owning channel.
REQ-014: Ch_Sel, output, SW, SHALL be the index of the owning channel.
REQ-015: Xfer_Go, output, 1, SHALL permit the channel engine to issue beats.
REQ-016: Busy, output, 1, SHALL indicate that the FSM is not in IDLE.
REQ-017: Ch_Irq, output, NUM_CH, SHALL be the sticky per-channel completion flags.
REQ-018: Interrupt, output, 1, SHALL be the OR of Ch_Irq.

Function
REQ-019: prev_req SHALL register DmacReq every cycle.
REQ-020: pending[i] SHALL set when DmacReq[i] & ~prev_req[i] & Ch_Mask[i], i.e. on a rising edge of an enabled request.
REQ-021: pending[i] SHALL clear on ReqAck[i] or when Ch_Mask[i]=0; if a set and an ack-clear occur in the same cycle, the set SHALL win.
REQ-022: The FSM SHALL have the states IDLE, ACK, BUS, ACTIVE.
REQ-023: In IDLE with any pending bit set, the winner SHALL be computed combinationally; at the next edge the FSM SHALL go to ACK, Ch_Sel SHALL be latched, and ReqAck[Ch_Sel] SHALL be 1 for exactly that ACK cycle.
REQ-024: ACK SHALL go to BUS unconditionally after one cycle.
REQ-025: In BUS and ACTIVE, Bus_Req SHALL be 1 and Ch_En SHALL be one-hot at Ch_Sel; in IDLE and ACK both SHALL be 0.
REQ-026: BUS SHALL go to ACTIVE at the first edge where Bus_Grant=1.
REQ-027: Xfer_Go SHALL be combinational: 1 only when the state is ACTIVE and Bus_Grant=1.
REQ-028: Loss of Bus_Grant in ACTIVE SHALL drop Xfer_Go in the same cycle, keep the channel as owner, and skip re-arbitration; Xfer_Go SHALL resume when the grant returns.
REQ-029: Ch_Done in ACTIVE SHALL cause IDLE at the next edge, set Ch_Irq[Ch_Sel], and update the round-robin pointer.
REQ-030: Ch_Done in any state other than ACTIVE SHALL be ignored.
REQ-031: In fixed-priority mode, the lowest pending index SHALL win.
REQ-032: In round-robin mode, the first pending index scanning upward from ptr SHALL win, wrapping from NUM_CH-1 to 0.
REQ-033: At Ch_Done, ptr SHALL become Ch_Sel+1, wrapping to 0 when Ch_Sel = NUM_CH-1.
REQ-034: Clearing Ch_Mask for the owning channel SHALL NOT abort its transfer; only its pending bit SHALL be affected.
REQ-035: Ch_Irq[i] SHALL clear on Irq_Clr[i]=1; if a set and a clear coincide, the set SHALL win.
REQ-036: The minimum latency from a request rising edge to Bus_Req SHALL be 3 edges: capture, ACK, BUS.
REQ-037: New requests arriving during a transfer SHALL be held pending and arbitrated in the first IDLE cycle after it.

Reset
REQ-038: While rst=0, the FSM SHALL be IDLE, and pending, prev_req, ptr, Ch_Sel and Ch_Irq SHALL be 0.
REQ-039: While rst=0, ReqAck, Bus_Req, Ch_En, Xfer_Go, Busy and Interrupt SHALL be 0.
REQ-040: Reset asserted mid-transfer SHALL drop all outputs immediately, without waiting for a clock edge.
REQ-041: After reset release, a request level already high SHALL NOT register as an edge until it falls and rises again.

Verification
REQ-042: NUM_CH=4, RR_MODE=0, DmacReq=4'b0110 rising together -> ReqAck=4'b0010 for 1 cycle; ch2 served only after Ch_Done for ch1.
REQ-043: RR_MODE=1, all four requests rising together, each Ch_Done after Bus_Grant -> service order 0,1,2,3; a new ch0 edge during ch3 -> ch0 next, with ptr wrapping 3->0.
REQ-044: Bus_Grant toggled 1,0,1 during ACTIVE -> Xfer_Go follows Bus_Grant, Ch_Sel unchanged, Bus_Req stays 1.
REQ-045: Ch_Done on ch1 together with Irq_Clr=4'b0010 -> Ch_Irq[1]=1 and Interrupt=1; Irq_Clr alone next cycle -> both 0.
REQ-046: Ch_Mask[2]=0 while ch2 is pending -> ch2 never acknowledged; Ch_Mask cleared during ch1 ACTIVE -> ch1 completes normally.
REQ-047: rst pulsed low during ACTIVE -> Bus_Req, Ch_En and Busy go to 0 asynchronously; DmacReq held high through the reset -> no ReqAck until it re-rises.
